two_d_counter_ring_b: RTL and testbench

TWO_D_COUNTER_RING_B -- requirements
Module: two_d_counter_ring_b

---
 rtl/two_d_counter_ring_b.sv | 101 ++++++++++
 tb/tb_two_d_counter_ring_b.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/two_d_counter_ring_b.sv
`default_nettype none
// ============================================================================
//  Module   : two_d_counter_ring_b
//  Purpose  : One dual-rail (NCL-style) counter digit.
//             Stores a single count bit q and adds the dual-rail carry-in to
//             it with a DATA/NULL four-phase handshake.
//             Cascading N digits (cout -> next cin, next cin_ack -> cout_ack)
//             gives an N-bit incrementer.
//  Ports    : clk      - clock; all state changes on the rising edge
//             init     - synchronous active-high reset
//             cin      - dual-rail carry-in  ([1] true rail, [0] false rail)
//             cin_ack  - completion to the previous stage (1 = DATA consumed)
//             sum      - dual-rail sum digit (2'b00 = NULL)
//             sum_ack  - completion from the sum consumer (1 = request NULL)
//             cout     - dual-rail carry-out to the next digit
//             cout_ack - completion from the next digit (1 = request NULL)
//  Revision : 1.0  initial release
// ============================================================================
module two_d_counter_ring_b #(
  parameter logic INIT_STATE   = 1'b0,
  parameter int   ILLEGAL_HOLD = 1
) (
  input  logic       clk,
  input  logic       init,
  input  logic [1:0] cin,
  output logic       cin_ack,
  output logic [1:0] sum,
  input  logic       sum_ack,
  output logic [1:0] cout,
  input  logic       cout_ack
);

  localparam logic [1:0] c_null    = 2'b00;
  localparam logic [1:0] c_illegal = 2'b11;

  logic       q_q,    q_d;
  logic [1:0] sum_q,  sum_d;
  logic [1:0] cout_q, cout_d;
  logic       ack_q,  ack_d;

  logic w_cin_data;
  logic w_cin_null;
  logic w_data_fire;
  logic w_null_fire;
  logic w_sum_bit;
  logic w_carry_bit;

  // Exactly one rail high is DATA. The illegal code either blocks both
  // wavefronts (hold) or is folded into NULL.
  assign w_cin_data = cin[1] ^ cin[0];
  assign w_cin_null = (cin == c_null) ||
                      ((ILLEGAL_HOLD == 0) && (cin == c_illegal));

  // DATA may only enter when both outputs are NULL and every consumer is
  // asking for DATA; otherwise the wavefront waits on the input.
  assign w_data_fire = w_cin_data && !ack_q && !sum_ack && !cout_ack &&
                       (sum_q == c_null) && (cout_q == c_null);

  assign w_null_fire = w_cin_null && ack_q && sum_ack && cout_ack;

  // Half adder on the stored bit and the true rail of the carry-in.
  assign w_sum_bit   = q_q ^ cin[1];
  assign w_carry_bit = q_q & cin[1];

  always_comb begin
    q_d    = q_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    ack_d  = ack_q;
    if (w_data_fire) begin
      q_d    = w_sum_bit;
      sum_d  = {w_sum_bit, ~w_sum_bit};
      cout_d = {w_carry_bit, ~w_carry_bit};
      ack_d  = 1'b1;
    end else if (w_null_fire) begin
      sum_d  = c_null;
      cout_d = c_null;
      ack_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (init) begin
      q_q    <= INIT_STATE;
      sum_q  <= c_null;
      cout_q <= c_null;
      ack_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ack_q  <= ack_d;
    end
  end

  assign sum     = sum_q;
  assign cout    = cout_q;
  assign cin_ack = ack_q;

endmodule
`default_nettype wire

// File: tb/tb_two_d_counter_ring_b.sv
`default_nettype none
// ============================================================================
//  Module   : tb_two_d_counter_ring_b
//  Purpose  : Self-checking bench for two_d_counter_ring_b. Two single-digit
//             instances (default parameters, and INIT_STATE=1/ILLEGAL_HOLD=0)
//             are compared against a behavioural model; an eight-digit cascade
//             is checked as a free-running incrementer through wrap-around.
//  Revision : 1.0  initial release
// ============================================================================
module tb_two_d_counter_ring_b;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       init;
  logic [1:0] cin;
  logic       sum_ack;
  logic       cout_ack;
  logic [1:0] sum0, cout0, sum1, cout1;
  logic       ack0, ack1;

  two_d_counter_ring_b dut0 (
    .clk(clk), .init(init), .cin(cin), .cin_ack(ack0),
    .sum(sum0), .sum_ack(sum_ack), .cout(cout0), .cout_ack(cout_ack)
  );

  two_d_counter_ring_b #(.INIT_STATE(1'b1), .ILLEGAL_HOLD(0)) dut1 (
    .clk(clk), .init(init), .cin(cin), .cin_ack(ack1),
    .sum(sum1), .sum_ack(sum_ack), .cout(cout1), .cout_ack(cout_ack)
  );

  // ---------------- eight-digit cascade -----------------------------------
  logic       casc_init;
  logic [1:0] cs_sum  [8];
  logic [1:0] cs_cout [8];
  logic       cs_ack  [8];

  for (genvar g = 0; g < 8; g++) begin : g_casc
    logic [1:0] cin_w;
    logic       cack_w;
    if (g == 0) begin : g_drv
      assign cin_w = {~casc_init & ~cs_ack[0], 1'b0};
    end else begin : g_chain
      assign cin_w = cs_cout[g-1];
    end
    if (g == 7) begin : g_last
      assign cack_w = |cs_cout[7];
    end else begin : g_mid
      assign cack_w = cs_ack[g+1];
    end
    two_d_counter_ring_b u_digit (
      .clk(clk), .init(casc_init), .cin(cin_w), .cin_ack(cs_ack[g]),
      .sum(cs_sum[g]), .sum_ack(|cs_sum[g]), .cout(cs_cout[g]),
      .cout_ack(cack_w)
    );
  end

  // ---------------- checking ---------------------------------------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // ---------------- behavioural model (index 0 = dut0, 1 = dut1) ----------
  int m_q[2], m_sum[2], m_cout[2], m_ack[2];

  // Dual-rail digit value v -> code: 1 -> 2 (true rail), 0 -> 1 (false rail)
  function automatic int enc(input int v);
    return (v != 0) ? 2 : 1;
  endfunction

  task automatic model_step(input int i);
    int ones;
    int total;
    bit is_data;
    bit is_null;
    ones    = int'(cin[1]) + int'(cin[0]);
    is_data = (ones == 1);
    is_null = (ones == 0) || (i == 1 && ones == 2);
    if (init) begin
      m_q[i] = i; m_sum[i] = 0; m_cout[i] = 0; m_ack[i] = 0;
    end else if (is_data && m_ack[i] == 0 && !sum_ack && !cout_ack &&
                 m_sum[i] == 0 && m_cout[i] == 0) begin
      total     = m_q[i] + int'(cin[1]);
      m_sum[i]  = enc(total % 2);
      m_cout[i] = enc(total / 2);
      m_q[i]    = total % 2;
      m_ack[i]  = 1;
    end else if (is_null && m_ack[i] == 1 && sum_ack && cout_ack) begin
      m_sum[i] = 0; m_cout[i] = 0; m_ack[i] = 0;
    end
  endtask

  // Advance one edge and compare both single-digit instances to the model.
  task automatic tick(input string tag);
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    chk({tag, "/sum0"},  int'(sum0),      m_sum[0]);
    chk({tag, "/cout0"}, int'(cout0),     m_cout[0]);
    chk({tag, "/ack0"},  int'(ack0),      m_ack[0]);
    chk({tag, "/q0"},    int'(dut0.q_q),  m_q[0]);
    chk({tag, "/sum1"},  int'(sum1),      m_sum[1]);
    chk({tag, "/cout1"}, int'(cout1),     m_cout[1]);
    chk({tag, "/ack1"},  int'(ack1),      m_ack[1]);
    chk({tag, "/q1"},    int'(dut1.q_q),  m_q[1]);
  endtask

  // ---------------- stimulus ---------------------------------------------
  bit hist [8][300];
  int wr   [8];
  bit prev_null [8];
  int k;
  int word;
  int bad_rails;

  initial begin
    casc_init = 1'b1;
    init      = 1'b1;
    cin       = 2'b00;
    sum_ack   = 1'b0;
    cout_ack  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_q[i] = 0; m_sum[i] = 0; m_cout[i] = 0; m_ack[i] = 0;
    end

    // Reset state
    tick("rst");
    tick("rst");
    chk("rst_sum0", int'(sum0), 0);
    chk("rst_ack0", int'(ack0), 0);
    chk("rst_q1",   int'(dut1.q_q), 1);

    // First DATA 1 from q=0
    init = 1'b0;
    cin  = 2'b10;
    tick("data1");
    chk("data1_sum0",  int'(sum0),  2);
    chk("data1_cout0", int'(cout0), 1);
    chk("data1_ack0",  int'(ack0),  1);
    chk("data1_q0",    int'(dut0.q_q), 1);

    // NULL phase, then second DATA 1 -> sum 0, carry 1
    cin = 2'b00; sum_ack = 1'b1; cout_ack = 1'b1;
    tick("null1");
    chk("null1_sum0", int'(sum0), 0);
    sum_ack = 1'b0; cout_ack = 1'b0; cin = 2'b10;
    tick("data2");
    chk("data2_sum0",  int'(sum0),  1);
    chk("data2_cout0", int'(cout0), 2);
    chk("data2_q0",    int'(dut0.q_q), 0);

    // DATA held while sum_ack still high: must wait
    cin = 2'b00; sum_ack = 1'b1; cout_ack = 1'b1;
    tick("null2");
    cin = 2'b10; cout_ack = 1'b0;
    for (int i = 0; i < 3; i++) tick("stall");
    chk("stall_sum0", int'(sum0), 0);
    chk("stall_ack0", int'(ack0), 0);
    sum_ack = 1'b0;
    tick("release");
    chk("release_sum0", int'(sum0), 2);
    chk("release_ack0", int'(ack0), 1);

    // Illegal code for five cycles with NULL-enabling acks
    cin = 2'b11; sum_ack = 1'b1; cout_ack = 1'b1;
    for (int i = 0; i < 5; i++) tick("illegal");
    chk("illegal_sum0", int'(sum0), 2);
    chk("illegal_ack0", int'(ack0), 1);

    // Reset mid-handshake
    init = 1'b1; cin = 2'b10;
    tick("midrst");
    chk("midrst_sum0", int'(sum0), 0);
    chk("midrst_ack0", int'(ack0), 0);
    chk("midrst_q1",   int'(dut1.q_q), 1);
    init = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cin      = 2'($urandom_range(0, 3));
      sum_ack  = 1'($urandom_range(0, 1));
      cout_ack = 1'($urandom_range(0, 1));
      init     = ($urandom_range(0, 59) == 0);
      tick("rand");
    end
    init = 1'b0;

    // ---------------- cascade incrementer ---------------------------------
    @(negedge clk);
    @(negedge clk);
    for (int s = 0; s < 8; s++) begin
      wr[s] = 0;
      prev_null[s] = 1'b1;
    end
    word = 0;
    for (int s = 0; s < 8; s++) word = word | (int'(cs_sum[s]) << (2 * s));
    chk("casc_rst_sums", word, 0);
    k = 0;
    bad_rails = 0;
    casc_init = 1'b0;
    for (int cyc = 0; cyc < 30000 && k < 257; cyc++) begin
      @(negedge clk);
      for (int s = 0; s < 8; s++) begin
        if (cs_sum[s] == 2'b11 || cs_cout[s] == 2'b11 ||
            ((cs_sum[s] == 2'b00) != (cs_cout[s] == 2'b00)))
          bad_rails++;
        if (cs_sum[s] != 2'b00 && prev_null[s]) begin
          hist[s][wr[s]] = cs_sum[s][1];
          wr[s]++;
          if (s == 7) begin
            k++;
            word = 0;
            for (int b = 0; b < 8; b++) word = word | (int'(hist[b][k-1]) << b);
            chk("casc_word", word, k % 256);
            chk("casc_cout", int'(cs_cout[7]), (k % 256 == 0) ? 2 : 1);
          end
        end
        prev_null[s] = (cs_sum[s] == 2'b00);
      end
    end
    if (k < 257) chk("casc_timeout", k, 257);
    chk("casc_rails", bad_rails, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
